vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, pixels per line (96 sync + 48 back + 640 active + 16 front).
REQ-002 SHALL have parameter H_ACT_START, default 144, first active h_cnt.
REQ-003 SHALL have parameter V_TOTAL, default 525, lines per frame (2 sync + 33 back + 480 active + 10 front).
REQ-004 SHALL have parameter V_ACT_START, default 35, first active v_cnt.
REQ-005 SHALL have ports: CLK in 1, pixel clock, the block's one clock; RST in 1, reset, synchronous, active-high.
REQ-006 SHALL have ports: VGA_HSYNC in 1 and VGA_VSYNC in 1, both active-low; VGA_RED, VGA_GREEN, VGA_BLUE in 4 each.
REQ-007 SHALL have ports: PROBE_X in 10, PROBE_Y in 10, probe coordinate.
REQ-008 SHALL have outputs: PIXEL_X out 10, PIXEL_Y out 10, PIXEL_RGB out 12 ({R,G,B}), PIXEL_VALID out 1.
REQ-009 SHALL have outputs: LOCKED out 1, FRAME_DONE out 1 (pulse), PROBE_RGB out 12, H_ERR out 1, V_ERR out 1.

Function
REQ-010 All inputs SHALL be registered once; sync edges SHALL be detected on registered values (registered level 1->0 = falling edge).
REQ-011 h_cnt SHALL be 0 in the cycle a HSYNC falling edge is detected, otherwise +1, saturating at 1023.
REQ-012 vs_armed SHALL be set whenever registered VSYNC is 1; at a HSYNC edge with registered VSYNC 0 and vs_armed 1 -> frame start: v_cnt <= 0, vs_armed cleared; at any other HSYNC edge v_cnt +1, saturating at 1023.
REQ-013 The FSM SHALL have states SEARCH, WAIT_FRAME and LOCKED; LOCKED output = (state == LOCKED).
REQ-014 SEARCH -> WAIT_FRAME SHALL occur after two consecutive HSYNC-edge-to-edge periods of exactly H_TOTAL cycles.
REQ-015 WAIT_FRAME -> LOCKED SHALL occur on the next frame start.
REQ-016 Line error SHALL be: HSYNC edge with period != H_TOTAL, or h_cnt reaching H_TOTAL without an edge; in WAIT_FRAME/LOCKED -> SEARCH and set H_ERR.
REQ-017 In LOCKED, a frame start with v_cnt != V_TOTAL-1 SHALL go to SEARCH and set V_ERR; with v_cnt == V_TOTAL-1 it SHALL pulse FRAME_DONE for 1 cycle and stay LOCKED.
REQ-018 Line errors in SEARCH SHALL only restart the two-line qualification; they SHALL NOT set H_ERR.
REQ-019 H_ERR and V_ERR SHALL be sticky; cleared only by RST.
REQ-020 PIXEL_VALID SHALL be 1 only when LOCKED and h_cnt in [H_ACT_START, H_ACT_START+639] and v_cnt in [V_ACT_START, V_ACT_START+479].
REQ-021 When valid: PIXEL_X = h_cnt-H_ACT_START and PIXEL_Y = v_cnt-V_ACT_START; PIXEL_RGB = registered RGB.
REQ-022 Outputs SHALL be registered; a pixel on the input pins SHALL appear on PIXEL_* 2 cycles later.
REQ-023 PIXEL_X/Y/RGB SHALL hold their last valid value while PIXEL_VALID is 0.
REQ-024 PROBE_RGB SHALL load PIXEL_RGB in the cycle after PIXEL_VALID with PIXEL_X==PROBE_X and PIXEL_Y==PROBE_Y; otherwise hold. An out-of-range probe never loads.
REQ-025 Simultaneous line error and frame start in LOCKED: line error SHALL win (SEARCH, H_ERR set, no FRAME_DONE).

Reset
REQ-026 On RST high at a CLK edge (including mid-frame), the block SHALL: set state SEARCH; h_cnt, v_cnt, vs_armed, input registers (syncs to 1) and all outputs to 0, except that the sync input registers SHALL be 1.
REQ-027 The first HSYNC edge after reset SHALL only start period measurement.

Configuration
REQ-028 With VGA_FRAME_SUM_EN defined: output FRAME_SUM out 24 SHALL be present; it accumulates the sum of PIXEL_RGB over valid pixels mod 2^24 and latches on FRAME_DONE, clearing the accumulator. Its reset value SHALL be 0, and the accumulator SHALL clear on any exit from LOCKED.
REQ-029 Without VGA_FRAME_SUM_EN: no FRAME_SUM port and no accumulator logic.

Verification
REQ-030 Standard 640x480 timing, constant RGB 12'h0F0 -> LOCKED asserts at first frame start after 2 good lines; PIXEL_VALID high 640x480 cycles per frame with PIXEL_RGB 12'h0F0.
REQ-031 Two full frames -> FRAME_DONE pulses exactly once per frame; H_ERR = V_ERR = 0.
REQ-032 One line of 799 cycles while LOCKED -> LOCKED=0, H_ERR=1 sticky; relock after clean lines plus frame start.
REQ-033 Frame of 524 lines while LOCKED -> V_ERR=1, LOCKED=0, no FRAME_DONE for that frame.
REQ-034 PROBE_X=639, PROBE_Y=479, input pixel 12'hF00 at that point only -> PROBE_RGB=12'hF00; pixel (0,0) is 2 cycles behind the input.
REQ-035 VGA_FRAME_SUM_EN, all pixels 12'h00F -> FRAME_SUM = 307200*15 mod 2^24 = 0x465000. RST mid-frame -> all outputs 0, LOCKED 0.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA sync/pixel decoder with lock FSM, pixel probe and optional frame checksum
//
// Recovers pixel coordinates from a VGA stream by counting pixel clocks between
// HSYNC falling edges and lines between frame starts. It only reports pixels once
// the line period and frame height have been confirmed.
//
// Optional feature macro: VGA_FRAME_SUM_EN adds FRAME_SUM, a per-frame 24-bit sum
// of all valid PIXEL_RGB values.
//
// Ports:
//   CLK, RST                 pixel clock, synchronous active-high reset
//   VGA_HSYNC, VGA_VSYNC     active-low sync inputs
//   VGA_RED/GREEN/BLUE       4-bit colour inputs
//   PROBE_X, PROBE_Y         coordinate whose colour is captured into PROBE_RGB
//   PIXEL_X/Y/RGB/VALID      decoded pixel, two cycles behind the input pins
//   LOCKED                   timing confirmed
//   FRAME_DONE               one-cycle pulse at each correctly sized frame end
//   PROBE_RGB                last colour seen at the probe coordinate
//   H_ERR, V_ERR             sticky line-period / frame-height errors
//   FRAME_SUM                (VGA_FRAME_SUM_EN only) last completed frame sum

module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        VGA_HSYNC,
    input  logic        VGA_VSYNC,
    input  logic [3:0]  VGA_RED,
    input  logic [3:0]  VGA_GREEN,
    input  logic [3:0]  VGA_BLUE,
    input  logic [9:0]  PROBE_X,
    input  logic [9:0]  PROBE_Y,
    output logic [9:0]  PIXEL_X,
    output logic [9:0]  PIXEL_Y,
    output logic [11:0] PIXEL_RGB,
    output logic        PIXEL_VALID,
    output logic        LOCKED,
    output logic        FRAME_DONE,
    output logic [11:0] PROBE_RGB,
    output logic        H_ERR,
    output logic        V_ERR
`ifdef VGA_FRAME_SUM_EN
    ,
    output logic [23:0] FRAME_SUM
`endif
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] CNT_MAX  = 10'd1023;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_END    = 10'(H_TOTAL);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_LO = 10'(H_ACT_START);
    localparam logic [9:0] H_ACT_HI = 10'(H_ACT_START + 639);
    localparam logic [9:0] V_ACT_LO = 10'(V_ACT_START);
    localparam logic [9:0] V_ACT_HI = 10'(V_ACT_START + 479);

    // input stage
    logic        hs_q, hs_d, hs_prev_q, hs_prev_d, vs_q, vs_d;
    logic [11:0] rgb_q, rgb_d;
    logic [9:0]  probe_x_q, probe_x_d, probe_y_q, probe_y_d;

    // timing recovery
    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        vs_armed_q, vs_armed_d;
    logic        seen_edge_q, seen_edge_d;
    logic        good_one_q, good_one_d;
    logic [1:0]  state_q, state_d;

    // outputs
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [11:0] pix_rgb_q, pix_rgb_d, probe_rgb_q, probe_rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic        frame_done_q, frame_done_d;
    logic        h_err_q, h_err_d, v_err_q, v_err_d;

    logic        hs_fall;
    logic [9:0]  h_cur;
    logic        frame_start;
    logic        period_ok;
    logic        line_err;
    logic        good_line;
    logic        in_active;

    assign hs_fall     = hs_prev_q & ~hs_q;
    // h_cur is the count belonging to the pixel currently in the input register,
    // so it is already 0 in the cycle the edge is seen.
    assign h_cur       = hs_fall ? 10'd0 : ((h_cnt_q == CNT_MAX) ? CNT_MAX : h_cnt_q + 10'd1);
    assign frame_start = hs_fall & ~vs_q & vs_armed_q;
    // h_cnt_q holds the last count of the previous line, i.e. period-1.
    assign period_ok   = (h_cnt_q == H_LAST);
    // The first edge after reset has no previous edge to measure against.
    assign line_err    = (hs_fall & seen_edge_q & ~period_ok) | (~hs_fall & (h_cur == H_END));
    assign good_line   = hs_fall & seen_edge_q & period_ok;
    assign in_active   = (state_q == ST_LOCKED)
                       && (h_cur >= H_ACT_LO) && (h_cur <= H_ACT_HI)
                       && (v_cnt_q >= V_ACT_LO) && (v_cnt_q <= V_ACT_HI);

    always_comb begin
        hs_d        = VGA_HSYNC;
        vs_d        = VGA_VSYNC;
        hs_prev_d   = hs_q;
        rgb_d       = {VGA_RED, VGA_GREEN, VGA_BLUE};
        probe_x_d   = PROBE_X;
        probe_y_d   = PROBE_Y;

        h_cnt_d     = h_cur;
        v_cnt_d     = v_cnt_q;
        vs_armed_d  = vs_armed_q;
        seen_edge_d = seen_edge_q | hs_fall;

        if (frame_start) begin
            v_cnt_d    = 10'd0;
            vs_armed_d = 1'b0;
        end else begin
            if (hs_fall && (v_cnt_q != CNT_MAX)) begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
            if (vs_q) begin
                vs_armed_d = 1'b1;
            end
        end

        state_d      = state_q;
        good_one_d   = good_one_q;
        h_err_d      = h_err_q;
        v_err_d      = v_err_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_SEARCH: begin
                if (line_err) begin
                    good_one_d = 1'b0;
                end else if (good_line) begin
                    if (good_one_q) begin
                        state_d    = ST_WAIT;
                        good_one_d = 1'b0;
                    end else begin
                        good_one_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (line_err) begin
                    state_d = ST_SEARCH;
                    h_err_d = 1'b1;
                end else if (frame_start) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A line error outranks a coincident frame start.
                if (line_err) begin
                    state_d = ST_SEARCH;
                    h_err_d = 1'b1;
                end else if (frame_start) begin
                    if (v_cnt_q != V_LAST) begin
                        state_d = ST_SEARCH;
                        v_err_d = 1'b1;
                    end else begin
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                good_one_d = 1'b0;
            end
        endcase

        pix_valid_d = in_active;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_rgb_d   = pix_rgb_q;
        if (in_active) begin
            pix_x_d   = h_cur - H_ACT_LO;
            pix_y_d   = v_cnt_q - V_ACT_LO;
            pix_rgb_d = rgb_q;
        end

        // Output coordinates never exceed 639/479, so an out-of-range probe never matches.
        probe_rgb_d = probe_rgb_q;
        if (pix_valid_q && (pix_x_q == probe_x_q) && (pix_y_q == probe_y_q)) begin
            probe_rgb_d = pix_rgb_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            hs_q         <= 1'b1;
            hs_prev_q    <= 1'b1;
            vs_q         <= 1'b1;
            rgb_q        <= 12'd0;
            probe_x_q    <= 10'd0;
            probe_y_q    <= 10'd0;
            h_cnt_q      <= 10'd0;
            v_cnt_q      <= 10'd0;
            vs_armed_q   <= 1'b0;
            seen_edge_q  <= 1'b0;
            good_one_q   <= 1'b0;
            state_q      <= ST_SEARCH;
            pix_x_q      <= 10'd0;
            pix_y_q      <= 10'd0;
            pix_rgb_q    <= 12'd0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            probe_rgb_q  <= 12'd0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
        end else begin
            hs_q         <= hs_d;
            hs_prev_q    <= hs_prev_d;
            vs_q         <= vs_d;
            rgb_q        <= rgb_d;
            probe_x_q    <= probe_x_d;
            probe_y_q    <= probe_y_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            vs_armed_q   <= vs_armed_d;
            seen_edge_q  <= seen_edge_d;
            good_one_q   <= good_one_d;
            state_q      <= state_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            probe_rgb_q  <= probe_rgb_d;
            h_err_q      <= h_err_d;
            v_err_q      <= v_err_d;
        end
    end

    assign PIXEL_X     = pix_x_q;
    assign PIXEL_Y     = pix_y_q;
    assign PIXEL_RGB   = pix_rgb_q;
    assign PIXEL_VALID = pix_valid_q;
    assign LOCKED      = (state_q == ST_LOCKED);
    assign FRAME_DONE  = frame_done_q;
    assign PROBE_RGB   = probe_rgb_q;
    assign H_ERR       = h_err_q;
    assign V_ERR       = v_err_q;

`ifdef VGA_FRAME_SUM_EN
    logic [23:0] acc_q, acc_d, frame_sum_q, frame_sum_d, acc_sum;

    always_comb begin
        acc_sum     = acc_q + (pix_valid_q ? {12'd0, pix_rgb_q} : 24'd0);
        acc_d       = acc_sum;
        frame_sum_d = frame_sum_q;
        if (frame_done_d) begin
            frame_sum_d = acc_sum;
            acc_d       = 24'd0;
        end
        // Losing lock discards a partial frame.
        if ((state_q == ST_LOCKED) && (state_d != ST_LOCKED)) begin
            acc_d = 24'd0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= 24'd0;
            frame_sum_q <= 24'd0;
        end else begin
            acc_q       <= acc_d;
            frame_sum_q <= frame_sum_d;
        end
    end

    assign FRAME_SUM = frame_sum_q;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - scoreboard testbench for vga_sync_decoder on a reduced raster
module tb_vga_sync_decoder;

    localparam int HT   = 40;
    localparam int HA   = 10;
    localparam int VT   = 20;
    localparam int VA   = 4;
    localparam int HS_W = 4;
    localparam int VS_L = 2;

    logic        CLK = 1'b0;
    logic        RST;
    logic        hsync, vsync;
    logic [3:0]  red, green, blue;
    logic [9:0]  probe_x, probe_y;
    logic [9:0]  pixel_x, pixel_y;
    logic [11:0] pixel_rgb, probe_rgb;
    logic        pixel_valid, locked, frame_done, h_err, v_err;
`ifdef VGA_FRAME_SUM_EN
    logic [23:0] frame_sum;
`endif

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [11:0] base_rgb, hot_rgb;
    int          hot_x, hot_y;
    int          fd_cnt;
    int          t_in00, t_out00;

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACT_START(HA), .V_TOTAL(VT), .V_ACT_START(VA)
    ) dut (
        .CLK(CLK), .RST(RST),
        .VGA_HSYNC(hsync), .VGA_VSYNC(vsync),
        .VGA_RED(red), .VGA_GREEN(green), .VGA_BLUE(blue),
        .PROBE_X(probe_x), .PROBE_Y(probe_y),
        .PIXEL_X(pixel_x), .PIXEL_Y(pixel_y), .PIXEL_RGB(pixel_rgb),
        .PIXEL_VALID(pixel_valid), .LOCKED(locked), .FRAME_DONE(frame_done),
        .PROBE_RGB(probe_rgb), .H_ERR(h_err), .V_ERR(v_err)
`ifdef VGA_FRAME_SUM_EN
        , .FRAME_SUM(frame_sum)
`endif
    );

    // Drives one line and checks every output cycle against the scoreboard.
    task automatic run_line(input int len, input int line_idx, input bit vs_low, input bit exp_valid);
        logic [11:0] col;
        logic [31:0] exp_px, got_px;
        for (int c = 0; c < len; c++) begin
            @(posedge CLK);
            #1;
            hsync = (c < HS_W) ? 1'b0 : 1'b1;
            vsync = vs_low ? 1'b0 : 1'b1;
            col = ((c - HA) == hot_x && (line_idx - VA) == hot_y) ? hot_rgb : base_rgb;
            {red, green, blue} = col;
            if (exp_valid && c >= HA && line_idx >= VA) begin
                sb.push_back({10'(c - HA), 10'(line_idx - VA), col});
                if (c == HA && line_idx == VA) t_in00 = cyc;
            end
            @(negedge CLK);
            if (frame_done) fd_cnt++;
            if (pixel_valid) begin
                n_run++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious_valid: got x=%0d y=%0d rgb=%h, expected no valid pixel",
                             pixel_x, pixel_y, pixel_rgb);
                end else begin
                    exp_px = sb.pop_front();
                    got_px = {pixel_x, pixel_y, pixel_rgb};
                    if (got_px !== exp_px) begin
                        n_fail++;
                        $display("FAIL pixel: got x=%0d y=%0d rgb=%h, expected x=%0d y=%0d rgb=%h",
                                 pixel_x, pixel_y, pixel_rgb, exp_px[31:22], exp_px[21:12], exp_px[11:0]);
                    end
                    if (pixel_x == 10'd0 && pixel_y == 10'd0) t_out00 = cyc;
                end
            end
        end
    endtask

    task automatic run_frame(input int n_lines, input bit exp_valid);
        for (int l = 0; l < n_lines; l++) run_line(HT, l, l < VS_L, exp_valid);
    endtask

    task automatic reset_on();
        @(posedge CLK);
        #1;
        RST = 1'b1;
        hsync = 1'b1;
        vsync = 1'b1;
        {red, green, blue} = 12'h000;
        sb.delete();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic reset_off();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        repeat (4) @(posedge CLK);
    endtask

    task automatic test_reset();
        reset_on();
        n_run++;
        if ({pixel_valid, locked, frame_done, h_err, v_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000", {pixel_valid, locked, frame_done, h_err, v_err});
        end
        n_run++;
        if ({pixel_x, pixel_y, pixel_rgb, probe_rgb} !== 44'd0) begin
            n_fail++;
            $display("FAIL reset_data: got x=%0d y=%0d rgb=%h probe=%h expected all 0",
                     pixel_x, pixel_y, pixel_rgb, probe_rgb);
        end
`ifdef VGA_FRAME_SUM_EN
        n_run++;
        if (frame_sum !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_sum: got %h expected 000000", frame_sum);
        end
`endif
        reset_off();
    endtask

    task automatic test_lock();
        base_rgb = 12'h0F0;
        hot_rgb  = 12'hF00;
        hot_x    = 29;
        hot_y    = 15;
        probe_x  = 10'd29;
        probe_y  = 10'd15;
        fd_cnt   = 0;
        run_frame(VT, 1'b0);
        n_run++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_wait: got LOCKED=%b expected 0", locked);
        end
        t_in00  = 0;
        t_out00 = -1000;
        run_frame(VT, 1'b1);
        n_run++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_first: got LOCKED=%b expected 1", locked);
        end
        n_run++;
        if (t_out00 - t_in00 != 2) begin
            n_fail++;
            $display("FAIL latency00: got %0d cycles expected 2", t_out00 - t_in00);
        end
        n_run++;
        if (fd_cnt != 0) begin
            n_fail++;
            $display("FAIL fd_lock_frame: got %0d pulses expected 0", fd_cnt);
        end
        for (int f = 0; f < 2; f++) begin
            fd_cnt = 0;
            run_frame(VT, 1'b1);
            n_run++;
            if (fd_cnt != 1) begin
                n_fail++;
                $display("FAIL fd_per_frame: got %0d pulses expected 1", fd_cnt);
            end
        end
        n_run++;
        if (probe_rgb !== 12'hF00) begin
            n_fail++;
            $display("FAIL probe_corner: got %h expected f00", probe_rgb);
        end
        n_run++;
        if ({h_err, v_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_clean: got H_ERR=%b V_ERR=%b expected 0 0", h_err, v_err);
        end
    endtask

    task automatic test_probe();
        hot_x   = -100;
        hot_y   = -100;
        probe_x = 10'd700;
        probe_y = 10'd2;
        run_frame(VT, 1'b1);
        n_run++;
        if (probe_rgb !== 12'hF00) begin
            n_fail++;
            $display("FAIL probe_oob_hold: got %h expected f00", probe_rgb);
        end
        probe_x = 10'd3;
        hot_x   = 3;
        hot_y   = 2;
        hot_rgb = 12'hABC;
        run_frame(VT, 1'b1);
        n_run++;
        if (probe_rgb !== 12'hABC) begin
            n_fail++;
            $display("FAIL probe_load: got %h expected abc", probe_rgb);
        end
        hot_x = -100;
        hot_y = -100;
    endtask

    task automatic test_line_error();
        base_rgb = 12'h5A5;
        fd_cnt   = 0;
        for (int l = 0; l < VT; l++) run_line((l == 6) ? HT - 1 : HT, l, l < VS_L, l <= 6);
        n_run++;
        if ({locked, h_err, v_err} !== 3'b010) begin
            n_fail++;
            $display("FAIL short_line: got LOCKED=%b H_ERR=%b V_ERR=%b expected 0 1 0", locked, h_err, v_err);
        end
        n_run++;
        if (fd_cnt != 1) begin
            n_fail++;
            $display("FAIL short_line_fd: got %0d pulses expected 1", fd_cnt);
        end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL short_line_missing: got %0d pixels not output expected 0", sb.size());
        end
        fd_cnt = 0;
        run_frame(VT, 1'b1);
        n_run++;
        if ({locked, h_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL relock: got LOCKED=%b H_ERR=%b expected 1 1", locked, h_err);
        end
        n_run++;
        if (fd_cnt != 0) begin
            n_fail++;
            $display("FAIL relock_fd: got %0d pulses expected 0", fd_cnt);
        end
    endtask

    task automatic test_short_frame();
        fd_cnt = 0;
        run_frame(VT - 1, 1'b1);
        n_run++;
        if (fd_cnt != 1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL short_frame_pre: got fd=%0d LOCKED=%b expected 1 1", fd_cnt, locked);
        end
        fd_cnt = 0;
        run_frame(VT, 1'b0);
        n_run++;
        if ({locked, v_err} !== 2'b01) begin
            n_fail++;
            $display("FAIL short_frame: got LOCKED=%b V_ERR=%b expected 0 1", locked, v_err);
        end
        n_run++;
        if (fd_cnt != 0) begin
            n_fail++;
            $display("FAIL short_frame_fd: got %0d pulses expected 0", fd_cnt);
        end
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL short_frame_missing: got %0d pixels not output expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        base_rgb = 12'h3C7;
        for (int l = 0; l < 8; l++) run_line(HT, l, l < VS_L, 1'b1);
        n_run++;
        if (locked !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_locked: got LOCKED=%b expected 1", locked);
        end
        reset_on();
        n_run++;
        if ({pixel_valid, locked, frame_done, h_err, v_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b expected 00000", {pixel_valid, locked, frame_done, h_err, v_err});
        end
        n_run++;
        if ({pixel_x, pixel_y, pixel_rgb, probe_rgb} !== 44'd0) begin
            n_fail++;
            $display("FAIL mid_reset_data: got x=%0d y=%0d rgb=%h probe=%h expected all 0",
                     pixel_x, pixel_y, pixel_rgb, probe_rgb);
        end
`ifdef VGA_FRAME_SUM_EN
        n_run++;
        if (frame_sum !== 24'd0) begin
            n_fail++;
            $display("FAIL mid_reset_sum: got %h expected 000000", frame_sum);
        end
`endif
        reset_off();
    endtask

`ifdef VGA_FRAME_SUM_EN
    task automatic test_frame_sum();
        base_rgb = 12'h00F;
        probe_x  = 10'd700;
        probe_y  = 10'd700;
        run_frame(VT, 1'b0);
        run_frame(VT, 1'b1);
        for (int f = 0; f < 2; f++) begin
            fd_cnt = 0;
            run_frame(VT, 1'b1);
            n_run++;
            if (frame_sum !== 24'h001C20 || fd_cnt != 1) begin
                n_fail++;
                $display("FAIL frame_sum: got %h fd=%0d expected 001c20 fd=1", frame_sum, fd_cnt);
            end
        end
    endtask
`endif

    initial begin
        RST      = 1'b1;
        hsync    = 1'b1;
        vsync    = 1'b1;
        red      = 4'h0;
        green    = 4'h0;
        blue     = 4'h0;
        probe_x  = 10'd0;
        probe_y  = 10'd0;
        base_rgb = 12'h000;
        hot_rgb  = 12'h000;
        hot_x    = -100;
        hot_y    = -100;
        fd_cnt   = 0;
        t_in00   = 0;
        t_out00  = 0;
        test_reset();
        test_lock();
        test_probe();
        test_line_error();
        test_short_frame();
        test_reset_mid();
`ifdef VGA_FRAME_SUM_EN
        test_frame_sum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
